// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle control FSM: states, opcodes, functs,
// ALU operation codes and PC source selects.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // Instructions whose second ALU operand is the sign-extended immediate.
  function automatic logic uses_imm(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational map from (opcode, funct) to the ALU operation and a flag
// saying whether the instruction is one this controller supports.
module alu_decode
  import cpu_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output logic [1:0] o_alu_ctrl,
  output logic       o_legal
);

  always_comb begin
    o_alu_ctrl = ALU_ADD;
    o_legal    = 1'b0;
    case (i_opcode)
      OP_R: begin
        case (i_funct)
          FN_ADD: begin o_alu_ctrl = ALU_ADD; o_legal = 1'b1; end
          FN_SUB: begin o_alu_ctrl = ALU_SUB; o_legal = 1'b1; end
          FN_AND: begin o_alu_ctrl = ALU_AND; o_legal = 1'b1; end
          FN_OR:  begin o_alu_ctrl = ALU_OR;  o_legal = 1'b1; end
          default: o_legal = 1'b0;
        endcase
      end
      OP_BEQ: begin
        o_alu_ctrl = ALU_SUB;
        o_legal    = 1'b1;
      end
      OP_J, OP_ADDI, OP_LW, OP_SW: o_legal = 1'b1;
      default: o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control unit: FETCH/DECODE/EXEC/MEM/WB sequencing,
// memory handshake with optional timeout, and a retired-instruction counter.
module multicycle_ctrl
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        can_branch,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        alu_src,
  output logic [1:0]  alu_ctrl,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        illegal,
  output logic        mem_fault,
  output logic [2:0]  state,
  output logic [31:0] instret
);

  localparam bit          TO_EN   = (MEM_TIMEOUT > 0);
  localparam logic [31:0] TO_LAST = (MEM_TIMEOUT > 0) ? 32'(MEM_TIMEOUT - 1) : 32'd0;

  state_t      r_state;
  logic [5:0]  r_opcode;
  logic [5:0]  r_funct;
  logic [31:0] r_instret;
  logic [31:0] r_wait;

  logic [5:0]  w_op;
  logic [5:0]  w_fn;
  logic [1:0]  w_alu_ctrl;
  logic        w_legal;
  logic        w_mem_phase;
  logic        w_timeout;
  logic        w_retire;

  // DECODE still sees the live instruction; later states use the latched copy.
  assign w_op = (r_state == ST_DECODE) ? opcode : r_opcode;
  assign w_fn = (r_state == ST_DECODE) ? funct  : r_funct;

  alu_decode u_alu_decode (
    .i_opcode   (w_op),
    .i_funct    (w_fn),
    .o_alu_ctrl (w_alu_ctrl),
    .o_legal    (w_legal)
  );

  assign w_mem_phase = (r_state == ST_FETCH) || (r_state == ST_MEM);
  assign w_timeout   = TO_EN && w_mem_phase && !mem_ready && (r_wait == TO_LAST);

  always_comb begin
    w_retire = 1'b0;
    case (r_state)
      ST_DECODE: w_retire = (w_op == OP_J);
      ST_EXEC:   w_retire = (r_opcode == OP_BEQ);
      ST_MEM:    w_retire = mem_ready && (r_opcode == OP_SW);
      ST_WB:     w_retire = 1'b1;
      default:   w_retire = 1'b0;
    endcase
  end

  // Outputs decode from the registered state; all of them drop while rst is high.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_SEQ;
    alu_src    = 1'b0;
    alu_ctrl   = ALU_ADD;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    mem_fault  = 1'b0;
    if (!rst) begin
      case (r_state)
        ST_FETCH: begin
          mem_req   = 1'b1;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
          pc_src    = PC_SEQ;
          mem_fault = w_timeout;
        end
        ST_DECODE: begin
          if (w_op == OP_J) begin
            pc_write = 1'b1;
            pc_src   = PC_JUMP;
          end else if (!w_legal) begin
            illegal = 1'b1;
          end
        end
        ST_EXEC: begin
          alu_src  = uses_imm(r_opcode);
          alu_ctrl = w_alu_ctrl;
          if (r_opcode == OP_BEQ) begin
            pc_write = can_branch;
            pc_src   = PC_BRANCH;
          end
        end
        ST_MEM: begin
          mem_req   = 1'b1;
          mem_we    = (r_opcode == OP_SW);
          mem_fault = w_timeout;
        end
        ST_WB: begin
          reg_write  = 1'b1;
          reg_dst    = (r_opcode == OP_R);
          mem_to_reg = (r_opcode == OP_LW);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_FETCH;
      r_opcode  <= 6'd0;
      r_funct   <= 6'd0;
      r_instret <= 32'd0;
      r_wait    <= 32'd0;
    end else begin
      if (w_retire) r_instret <= r_instret + 32'd1;

      // Consecutive unanswered request cycles; cleared on any completion or fault.
      if (TO_EN && w_mem_phase && !mem_ready && !w_timeout) r_wait <= r_wait + 32'd1;
      else                                                  r_wait <= 32'd0;

      case (r_state)
        ST_FETCH: begin
          if (mem_ready) r_state <= ST_DECODE;
          else           r_state <= ST_FETCH;
        end
        ST_DECODE: begin
          r_opcode <= opcode;
          r_funct  <= funct;
          if ((w_op == OP_J) || !w_legal) r_state <= ST_FETCH;
          else                            r_state <= ST_EXEC;
        end
        ST_EXEC: begin
          if (r_opcode == OP_BEQ)                           r_state <= ST_FETCH;
          else if ((r_opcode == OP_LW) || (r_opcode == OP_SW)) r_state <= ST_MEM;
          else                                              r_state <= ST_WB;
        end
        ST_MEM: begin
          if (mem_ready) begin
            if (r_opcode == OP_SW) r_state <= ST_FETCH;
            else                   r_state <= ST_WB;
          end else if (w_timeout) begin
            r_state <= ST_FETCH;
          end
        end
        ST_WB:   r_state <= ST_FETCH;
        default: r_state <= ST_FETCH;
      endcase
    end
  end

  assign state   = r_state;
  assign instret = r_instret;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: an instruction-level model predicts every cycle's
// outputs for two instances (timeout disabled, and timeout of 4 cycles).
module tb_multicycle_ctrl;
  import cpu_pkg::*;

  localparam logic [16:0] FULL     = 17'h1FFFF;
  // state, mem_req, ir_write, pc_write, reg_write, illegal, mem_fault
  localparam logic [16:0] RST_MASK = 17'b111_1_0_1_1_00_0_00_0_0_1_1_1;
  localparam int K_R = 0, K_J = 1, K_BEQ = 2, K_ADDI = 3, K_LW = 4, K_SW = 5, K_ILL = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_v[2], cb_v[2], rdy_v[2];
  logic [5:0] op_v[2], fn_v[2];
  logic       req_o[2], we_o[2], irw_o[2], pcw_o[2], as_o[2], rd_o[2], m2r_o[2], rw_o[2], ill_o[2], mf_o[2];
  logic [1:0] pcs_o[2], ac_o[2];
  logic [2:0] st_o[2];
  logic [31:0] ins_o[2];

  multicycle_ctrl u_dut0 (
    .clk(clk), .rst(rst_v[0]), .opcode(op_v[0]), .funct(fn_v[0]),
    .can_branch(cb_v[0]), .mem_ready(rdy_v[0]),
    .mem_req(req_o[0]), .mem_we(we_o[0]), .ir_write(irw_o[0]), .pc_write(pcw_o[0]),
    .pc_src(pcs_o[0]), .alu_src(as_o[0]), .alu_ctrl(ac_o[0]), .reg_dst(rd_o[0]),
    .mem_to_reg(m2r_o[0]), .reg_write(rw_o[0]), .illegal(ill_o[0]), .mem_fault(mf_o[0]),
    .state(st_o[0]), .instret(ins_o[0])
  );

  multicycle_ctrl #(.MEM_TIMEOUT(4)) u_dut1 (
    .clk(clk), .rst(rst_v[1]), .opcode(op_v[1]), .funct(fn_v[1]),
    .can_branch(cb_v[1]), .mem_ready(rdy_v[1]),
    .mem_req(req_o[1]), .mem_we(we_o[1]), .ir_write(irw_o[1]), .pc_write(pcw_o[1]),
    .pc_src(pcs_o[1]), .alu_src(as_o[1]), .alu_ctrl(ac_o[1]), .reg_dst(rd_o[1]),
    .mem_to_reg(m2r_o[1]), .reg_write(rw_o[1]), .illegal(ill_o[1]), .mem_fault(mf_o[1]),
    .state(st_o[1]), .instret(ins_o[1])
  );

  // ---------------- model state and scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  int n_steps  = 0;
  logic [31:0] model_instret[2];
  // {idx, instret, mask, vec}
  logic [66:0] exp_q[$];
  logic [66:0] cmp_e;
  int          cmp_i;

  function automatic logic [16:0] ev(input logic [2:0] st, input logic req, we, irw, pcw,
                                     input logic [1:0] pcs, input logic as, input logic [1:0] ac,
                                     input logic rd, m2r, rw, ill, mf);
    return {st, req, we, irw, pcw, pcs, as, ac, rd, m2r, rw, ill, mf};
  endfunction

  function automatic logic [16:0] act_vec(input int i);
    return {st_o[i], req_o[i], we_o[i], irw_o[i], pcw_o[i], pcs_o[i], as_o[i], ac_o[i],
            rd_o[i], m2r_o[i], rw_o[i], ill_o[i], mf_o[i]};
  endfunction

  function automatic int kind(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      OP_R:    return (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25) ? K_R : K_ILL;
      OP_J:    return K_J;
      OP_BEQ:  return K_BEQ;
      OP_ADDI: return K_ADDI;
      OP_LW:   return K_LW;
      OP_SW:   return K_SW;
      default: return K_ILL;
    endcase
  endfunction

  function automatic logic [1:0] alu_of(input int k, input logic [5:0] fn);
    if (k == K_BEQ) return 2'b01;
    if (k != K_R) return 2'b00;
    case (fn)
      6'h22:   return 2'b01;
      6'h24:   return 2'b10;
      6'h25:   return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  task automatic check_vec(input string name, input int i, input logic [16:0] a, input logic [16:0] e);
    n_checks++;
    if (a !== e) begin
      n_errors++;
      $display("FAIL %s dut%0d t=%0t: got %05h expected %05h", name, i, $time, a, e);
    end
  endtask

  task automatic check32(input string name, input int i, input logic [31:0] a, input logic [31:0] e);
    n_checks++;
    if (a !== e) begin
      n_errors++;
      $display("FAIL %s dut%0d t=%0t: got %0d expected %0d", name, i, $time, a, e);
    end
  endtask

  task automatic check_int(input string name, input int a, input int e);
    n_checks++;
    if (a != e) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, a, e);
    end
  endtask

  // Single compare process: one expectation per driven cycle, checked mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cmp_e = exp_q.pop_front();
      cmp_i = int'(cmp_e[66]);
      check_vec("outputs", cmp_i, act_vec(cmp_i) & cmp_e[33:17], cmp_e[16:0] & cmp_e[33:17]);
      check32("instret", cmp_i, ins_o[cmp_i], cmp_e[65:34]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int idx, input logic r, input logic rdy, input logic cb,
                      input logic [5:0] op, input logic [5:0] fn,
                      input logic [16:0] e, input logic [16:0] m);
    rst_v[idx] = r;
    rdy_v[idx] = rdy;
    cb_v[idx]  = cb;
    op_v[idx]  = op;
    fn_v[idx]  = fn;
    exp_q.push_back({idx[0], model_instret[idx], m, e});
    n_steps++;
    @(posedge clk);
    #1;
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [5:0] r6();
    return 6'($urandom_range(0, 63));
  endfunction

  task automatic do_reset(input int idx);
    rst_v[idx] = 1'b1;
    @(posedge clk);
    #1;
    model_instret[idx] = 32'd0;
    step(idx, 1'b1, rb(), rb(), r6(), r6(), ev(3'd0, 0,0,0,0, 2'b00, 0, 2'b00, 0,0,0,0,0), RST_MASK);
  endtask

  // Request phase (FETCH or MEM): ready arrives after wait_n idle cycles,
  // unless the timeout of the instance fires first.
  task automatic mem_loop(input int idx, input logic [2:0] st, input logic we,
                          input int wait_n, output logic ok);
    int to;
    logic rdy, flt, irw;
    to = (idx == 1) ? 4 : 0;
    ok = 1'b0;
    for (int c = 0; c < 64; c++) begin
      rdy = (c == wait_n);
      flt = !rdy && (to > 0) && (c == to - 1);
      irw = (st == 3'd0) && rdy;
      step(idx, 1'b0, rdy, rb(), r6(), r6(),
           ev(st, 1'b1, we, irw, irw, 2'b00, 0, 2'b00, 0,0,0,0, flt), FULL);
      if (rdy) begin
        ok = 1'b1;
        break;
      end
      if (flt) break;
    end
  endtask

  task automatic run_instr(input int idx, input logic [5:0] op, input logic [5:0] fn,
                           input logic cb, input int fw, input int mw, output int cyc);
    int k, start;
    logic ok, isj, isb, isl, iss, as;
    start = n_steps;
    k   = kind(op, fn);
    isj = (k == K_J);
    isb = (k == K_BEQ);
    isl = (k == K_LW);
    iss = (k == K_SW);
    as  = (k == K_ADDI) || isl || iss;
    mem_loop(idx, 3'd0, 1'b0, fw, ok);
    if (ok) begin
      step(idx, 1'b0, rb(), rb(), op, fn,
           ev(3'd1, 0,0,0, isj, isj ? 2'b10 : 2'b00, 0, 2'b00, 0,0,0, (k == K_ILL), 0), FULL);
      if (isj) model_instret[idx]++;
      if (!isj && k != K_ILL) begin
        step(idx, 1'b0, rb(), cb, r6(), r6(),
             ev(3'd2, 0,0,0, isb & cb, isb ? 2'b01 : 2'b00, as, alu_of(k, fn), 0,0,0,0,0), FULL);
        if (isb) model_instret[idx]++;
        ok = 1'b1;
        if (isl || iss) begin
          mem_loop(idx, 3'd3, iss, mw, ok);
          if (ok && iss) model_instret[idx]++;
        end
        if (k == K_R || k == K_ADDI || (isl && ok)) begin
          step(idx, 1'b0, rb(), rb(), r6(), r6(),
               ev(3'd4, 0,0,0,0, 2'b00, 0, 2'b00, (k == K_R), isl, 1'b1, 0,0), FULL);
          model_instret[idx]++;
        end
      end
    end
    cyc = n_steps - start;
  endtask

  // sw aborted by reset in its second MEM wait cycle.
  task automatic sw_reset(input int idx);
    logic ok;
    mem_loop(idx, 3'd0, 1'b0, 0, ok);
    step(idx, 1'b0, rb(), rb(), OP_SW, r6(), ev(3'd1, 0,0,0,0, 2'b00, 0, 2'b00, 0,0,0,0,0), FULL);
    step(idx, 1'b0, rb(), rb(), r6(), r6(), ev(3'd2, 0,0,0,0, 2'b00, 1, 2'b00, 0,0,0,0,0), FULL);
    step(idx, 1'b0, 1'b0, rb(), r6(), r6(), ev(3'd3, 1,1,0,0, 2'b00, 0, 2'b00, 0,0,0,0,0), FULL);
    step(idx, 1'b1, 1'b1, rb(), r6(), r6(), ev(3'd3, 0,0,0,0, 2'b00, 0, 2'b00, 0,0,0,0,0), RST_MASK);
    model_instret[idx] = 32'd0;
    check32("rst_abort_instret", idx, ins_o[idx], 32'd0);
    check32("rst_abort_state", idx, 32'(st_o[idx]), 32'd0);
  endtask

  task automatic run_random(input int idx, input int n);
    int sel, cyc;
    logic [5:0] op, fn;
    logic [5:0] rfn[4];
    rfn[0] = 6'h20; rfn[1] = 6'h22; rfn[2] = 6'h24; rfn[3] = 6'h25;
    for (int i = 0; i < n; i++) begin
      sel = $urandom_range(0, 9);
      fn  = r6();
      case (sel)
        0:       begin op = OP_R; fn = rfn[$urandom_range(0, 3)]; end
        1:       op = OP_R;
        2:       op = OP_J;
        3:       op = OP_BEQ;
        4:       op = OP_ADDI;
        5, 8:    op = OP_LW;
        6, 9:    op = OP_SW;
        default: op = r6();
      endcase
      run_instr(idx, op, fn, rb(), $urandom_range(0, (idx == 1) ? 5 : 3),
                $urandom_range(0, (idx == 1) ? 6 : 3), cyc);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cyc;
    for (int i = 0; i < 2; i++) begin
      rst_v[i] = 1'b1; cb_v[i] = 1'b0; rdy_v[i] = 1'b0; op_v[i] = 6'd0; fn_v[i] = 6'd0;
      model_instret[i] = 32'd0;
    end

    do_reset(0);
    run_instr(0, OP_R, FN_ADD, 1'b0, 0, 0, cyc);   check_int("lat_add", cyc, 4);
    check32("instret_after_add", 0, ins_o[0], 32'd1);
    run_instr(0, OP_LW, 6'h11, 1'b0, 0, 3, cyc);    check_int("lat_lw_wait3", cyc, 8);
    run_instr(0, OP_BEQ, 6'h00, 1'b1, 0, 0, cyc);   check_int("lat_beq_taken", cyc, 3);
    run_instr(0, OP_BEQ, 6'h00, 1'b0, 0, 0, cyc);   check_int("lat_beq_not", cyc, 3);
    check32("instret_after_beqs", 0, ins_o[0], 32'd4);
    run_instr(0, OP_J, 6'h3F, 1'b0, 0, 0, cyc);     check_int("lat_j", cyc, 2);
    run_instr(0, OP_SW, 6'h00, 1'b0, 0, 0, cyc);    check_int("lat_sw", cyc, 4);
    run_instr(0, OP_ADDI, 6'h05, 1'b0, 2, 0, cyc);  check_int("lat_addi_fwait2", cyc, 6);
    run_instr(0, 6'h3F, 6'h20, 1'b0, 0, 0, cyc);    check_int("lat_illegal_op", cyc, 2);
    run_instr(0, OP_R, 6'h27, 1'b0, 0, 0, cyc);     check_int("lat_illegal_fn", cyc, 2);
    check32("instret_after_illegal", 0, ins_o[0], 32'd7);
    sw_reset(0);
    run_random(0, 150);

    rst_v[0] = 1'b1;
    do_reset(1);
    run_instr(1, OP_SW, 6'h00, 1'b0, 0, 10, cyc);   check_int("lat_sw_timeout", cyc, 7);
    check32("instret_after_timeout", 1, ins_o[1], 32'd0);
    run_instr(1, OP_R, FN_OR, 1'b0, 9, 0, cyc);     check_int("lat_fetch_timeout", cyc, 4);
    run_instr(1, OP_LW, 6'h00, 1'b0, 0, 3, cyc);    check_int("lat_lw_ready_last", cyc, 8);
    run_instr(1, OP_LW, 6'h00, 1'b0, 0, 4, cyc);    check_int("lat_lw_timeout", cyc, 7);
    check32("instret_after_lw_pair", 1, ins_o[1], 32'd1);
    run_random(1, 150);

    rst_v[1] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    check_int("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    n_errors++;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
